// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle IF/ID/EX/MEM/WB control FSM for an RV32I-subset datapath.
// Define CTRL_INSTR_COUNT_EN to add the 32-bit 'retired' instruction counter output.
module ctrl_fsm #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  output logic        ALUSrc,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        PCSrc,
  output logic        loadPC,
  output logic [3:0]  ALUCtrl,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  state_o
`ifdef CTRL_INSTR_COUNT_EN
  ,
  output logic [31:0] retired
`endif
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  // Counter is loaded with MEM_LAT-1 so MEM lasts exactly MEM_LAT cycles.
  localparam logic [3:0] MEM_CNT_INIT = 4'(MEM_LAT - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] mem_cnt_q, mem_cnt_d;
  logic       taken_q, taken_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       is_r, is_i, is_load, is_store, is_branch, is_mem;
  logic       br_taken;
  logic [3:0] alu_dec;
  logic       unused_instr_bits;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7_5  = instr[30];
  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BR);
  assign is_mem    = is_load | is_store;
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  assign br_taken = is_branch &&
                    (((funct3 == 3'b000) && Zero) || ((funct3 == 3'b001) && !Zero));

  // Immediate ops never subtract; only funct3=101 looks at funct7[5] for them.
  always_comb begin
    alu_dec = ALU_ADD;
    if (is_r || is_i) begin
      case (funct3)
        3'b000:         alu_dec = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
        3'b001:         alu_dec = ALU_SLL;
        3'b010, 3'b011: alu_dec = ALU_SLT;
        3'b100:         alu_dec = ALU_XOR;
        3'b101:         alu_dec = funct7_5 ? ALU_SRA : ALU_SRL;
        3'b110:         alu_dec = ALU_OR;
        default:        alu_dec = ALU_AND;
      endcase
    end else if (is_branch) begin
      alu_dec = ALU_SUB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IF;
      mem_cnt_q <= '0;
      taken_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_cnt_q <= mem_cnt_d;
      taken_q   <= taken_d;
    end
  end

  always_comb begin
    state_d   = S_IF;
    mem_cnt_d = mem_cnt_q;
    taken_d   = taken_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: state_d = S_EX;
      S_EX: begin
        state_d   = S_MEM;
        mem_cnt_d = is_mem ? MEM_CNT_INIT : 4'd0;
        taken_d   = br_taken;
      end
      S_MEM: begin
        if (is_mem && (mem_cnt_q != 4'd0)) begin
          state_d   = S_MEM;
          mem_cnt_d = mem_cnt_q - 4'd1;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB:    state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  // Strobes are masked while rst is high so an aborted instruction never writes.
  always_comb begin
    ALUSrc   = 1'b0;
    ALUCtrl  = ALU_ADD;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    loadPC   = 1'b0;
    PCSrc    = 1'b0;
    if (state_q inside {S_ID, S_EX, S_MEM, S_WB}) begin
      ALUCtrl = alu_dec;
      ALUSrc  = is_i | is_load | is_store;
    end
    if (!rst) begin
      if (state_q == S_MEM) begin
        MemRead  = is_load;
        MemWrite = is_store;
      end
      if (state_q == S_WB) begin
        RegWrite = is_r | is_i | is_load;
        MemToReg = is_load;
        loadPC   = 1'b1;
        PCSrc    = taken_q;
      end
    end
  end

  assign state_o = state_q;

`ifdef CTRL_INSTR_COUNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else if (loadPC) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: scoreboard bench for ctrl_fsm; three instances with MEM_LAT = 1, 3, 4.
// Expected per-cycle output vectors are queued when stimulus is applied and popped each cycle.
module tb_ctrl_fsm;
  localparam logic [3:0] A_AND = 4'b0000, A_OR  = 4'b0001, A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110, A_SLT = 4'b0100, A_SRL = 4'b1000;
  localparam logic [3:0] A_SLL = 4'b1001, A_SRA = 4'b1010, A_XOR = 4'b1101;
  // strobe field order: {MemRead, MemWrite, RegWrite, MemToReg, loadPC, PCSrc}
  localparam logic [5:0] S_NONE = 6'b000000, S_MR = 6'b100000, S_MW = 6'b010000;
  localparam logic [5:0] S_LPC = 6'b000010, S_RWB = 6'b001010, S_LDWB = 6'b001110;
  localparam logic [5:0] S_BRT = 6'b000011;
  localparam logic [31:0] I_ADD = 32'h002081B3, I_LW = 32'h0000A183, I_SW = 32'h0020A023;
  localparam logic [31:0] I_BEQ = 32'h00208463, I_BNE = 32'h00209463;
  localparam logic [31:0] I_SRAI = 32'h4020D193, I_SRLI = 32'h0020D193;
  localparam logic [31:0] I_ADDI = 32'h00108193, I_BAD = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Zero = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [13:0] obs [3];
  logic [13:0] exp_q [$];
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int unsigned LAT = (gi == 0) ? 1 : ((gi == 1) ? 3 : 4);
    logic       src, m2r, rw, pcs, lpc, mr, mw;
    logic [3:0] alu;
    logic [2:0] st;
`ifdef CTRL_INSTR_COUNT_EN
    logic [31:0] ret;
`endif
    ctrl_fsm #(.MEM_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst), .instr(instr), .Zero(Zero),
      .ALUSrc(src), .MemToReg(m2r), .RegWrite(rw), .PCSrc(pcs), .loadPC(lpc),
      .ALUCtrl(alu), .MemRead(mr), .MemWrite(mw), .state_o(st)
`ifdef CTRL_INSTR_COUNT_EN
      , .retired(ret)
`endif
    );
    assign obs[gi] = {st, src, alu, mr, mw, rw, m2r, lpc, pcs};
  end

  function automatic logic [13:0] mk(input logic [2:0] st, input logic src,
                                     input logic [3:0] alu, input logic [5:0] strb);
    return {st, src, alu, strb};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; Zero = 1'b0; instr = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] e;
    rst = 1'b1; instr = I_ADD; Zero = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(3'd0, 1'b0, A_ADD, S_NONE));
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front(); n_total++;
      if (obs[k] !== e) $display("FAIL reset_inst%0d got=%h exp=%h", k, obs[k], e);
      else n_pass++;
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(mk(3'd0, 1'b0, A_ADD, S_NONE));
    @(negedge clk);
    e = exp_q.pop_front(); n_total++;
    if (obs[0] !== e) $display("FAIL reset_from_ex got=%h exp=%h", obs[0], e);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_r_type();
    logic [13:0] e;
    int cyc = 0;
    do_reset();
    instr = I_ADD; Zero = 1'b1;
    exp_q.push_back(mk(3'd0, 1'b0, A_ADD, S_NONE));
    for (int s = 1; s <= 3; s++) exp_q.push_back(mk(3'(s), 1'b0, A_ADD, S_NONE));
    exp_q.push_back(mk(3'd4, 1'b0, A_ADD, S_RWB));
    exp_q.push_back(mk(3'd0, 1'b0, A_ADD, S_NONE));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs[0] !== e) $display("FAIL add_cyc%0d got=%h exp=%h", cyc, obs[0], e);
      else n_pass++;
      cyc++;
      if (exp_q.size() != 0) @(negedge clk);
    end
  endtask

  task automatic test_load();
    logic [13:0] e;
    int cyc = 0;
    do_reset();
    instr = I_LW;
    exp_q.push_back(mk(3'd0, 1'b0, A_ADD, S_NONE));
    exp_q.push_back(mk(3'd1, 1'b1, A_ADD, S_NONE));
    exp_q.push_back(mk(3'd2, 1'b1, A_ADD, S_NONE));
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(3'd3, 1'b1, A_ADD, S_MR));
    exp_q.push_back(mk(3'd4, 1'b1, A_ADD, S_LDWB));
    exp_q.push_back(mk(3'd0, 1'b0, A_ADD, S_NONE));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs[1] !== e) $display("FAIL lw_lat3_cyc%0d got=%h exp=%h", cyc, obs[1], e);
      else n_pass++;
      cyc++;
      if (exp_q.size() != 0) @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [31:0] b_i [3] = '{I_BEQ, I_BEQ, I_BNE};
    logic        b_z [3] = '{1'b1, 1'b0, 1'b0};
    logic [5:0]  b_w [3] = '{S_BRT, S_LPC, S_BRT};
    logic [13:0] e;
    for (int t = 0; t < 3; t++) begin
      int cyc = 0;
      do_reset();
      instr = b_i[t]; Zero = b_z[t];
      exp_q.push_back(mk(3'd0, 1'b0, A_ADD, S_NONE));
      for (int s = 1; s <= 3; s++) exp_q.push_back(mk(3'(s), 1'b0, A_SUB, S_NONE));
      exp_q.push_back(mk(3'd4, 1'b0, A_SUB, b_w[t]));
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front(); n_total++;
        if (obs[0] !== e) $display("FAIL branch%0d_cyc%0d got=%h exp=%h", t, cyc, obs[0], e);
        else n_pass++;
        cyc++;
        if (exp_q.size() != 0) @(negedge clk);
      end
    end
  endtask

  task automatic test_shift_imm();
    logic [31:0] s_i [2] = '{I_SRAI, I_SRLI};
    logic [3:0]  s_a [2] = '{A_SRA, A_SRL};
    logic [13:0] e;
    for (int t = 0; t < 2; t++) begin
      int cyc = 0;
      do_reset();
      instr = s_i[t];
      exp_q.push_back(mk(3'd0, 1'b0, A_ADD, S_NONE));
      for (int s = 1; s <= 3; s++) exp_q.push_back(mk(3'(s), 1'b1, s_a[t], S_NONE));
      exp_q.push_back(mk(3'd4, 1'b1, s_a[t], S_RWB));
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front(); n_total++;
        if (obs[0] !== e) $display("FAIL shift%0d_cyc%0d got=%h exp=%h", t, cyc, obs[0], e);
        else n_pass++;
        cyc++;
        if (exp_q.size() != 0) @(negedge clk);
      end
    end
  endtask

  task automatic test_alu_decode();
    logic [31:0] d_i [10] = '{32'h402081B3, 32'h0020C1B3, 32'h0020E1B3, 32'h0020F1B3,
                              32'h0020A1B3, 32'h002091B3, 32'h4020D1B3, I_ADDI, I_SW, I_BAD};
    logic [4:0]  d_e [10] = '{{1'b0, A_SUB}, {1'b0, A_XOR}, {1'b0, A_OR}, {1'b0, A_AND},
                              {1'b0, A_SLT}, {1'b0, A_SLL}, {1'b0, A_SRA}, {1'b1, A_ADD},
                              {1'b1, A_ADD}, {1'b0, A_ADD}};
    logic [13:0] e;
    for (int t = 0; t < 10; t++) begin
      do_reset();
      instr = d_i[t];
      exp_q.push_back(mk(3'd1, d_e[t][4], d_e[t][3:0], S_NONE));
      @(negedge clk);
      e = exp_q.pop_front(); n_total++;
      if (obs[0] !== e) $display("FAIL decode%0d instr=%h got=%h exp=%h", t, d_i[t], obs[0], e);
      else n_pass++;
    end
  endtask

  task automatic test_unsupported();
    logic [13:0] e;
    int cyc = 0;
    do_reset();
    instr = I_BAD; Zero = 1'b1;
    exp_q.push_back(mk(3'd0, 1'b0, A_ADD, S_NONE));
    for (int s = 1; s <= 3; s++) exp_q.push_back(mk(3'(s), 1'b0, A_ADD, S_NONE));
    exp_q.push_back(mk(3'd4, 1'b0, A_ADD, S_LPC));
    exp_q.push_back(mk(3'd0, 1'b0, A_ADD, S_NONE));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs[0] !== e) $display("FAIL badop_cyc%0d got=%h exp=%h", cyc, obs[0], e);
      else n_pass++;
      cyc++;
      if (exp_q.size() != 0) @(negedge clk);
    end
  endtask

  task automatic test_store_abort();
    logic [13:0] e;
    int cyc = 0;
    do_reset();
    instr = I_SW;
    exp_q.push_back(mk(3'd0, 1'b0, A_ADD, S_NONE));
    exp_q.push_back(mk(3'd1, 1'b1, A_ADD, S_NONE));
    exp_q.push_back(mk(3'd2, 1'b1, A_ADD, S_NONE));
    exp_q.push_back(mk(3'd3, 1'b1, A_ADD, S_MW));
    exp_q.push_back(mk(3'd3, 1'b1, A_ADD, S_MW));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs[2] !== e) $display("FAIL sw_lat4_cyc%0d got=%h exp=%h", cyc, obs[2], e);
      else n_pass++;
      cyc++;
      if (exp_q.size() != 0) @(negedge clk);
    end
    #1 rst = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(3'd0, 1'b0, A_ADD, S_NONE));
    while (exp_q.size() != 0) begin
      @(negedge clk);
      e = exp_q.pop_front(); n_total++;
      if (obs[2] !== e) $display("FAIL sw_abort_cyc%0d got=%h exp=%h", cyc, obs[2], e);
      else n_pass++;
      cyc++;
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [13:0] e;
    int cyc = 0;
    do_reset();
    instr = I_ADDI;
    exp_q.push_back(mk(3'd0, 1'b0, A_ADD, S_NONE));
    for (int s = 1; s <= 3; s++) exp_q.push_back(mk(3'(s), 1'b1, A_ADD, S_NONE));
    exp_q.push_back(mk(3'd4, 1'b1, A_ADD, S_RWB));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs[0] !== e) $display("FAIL b2b_addi_cyc%0d got=%h exp=%h", cyc, obs[0], e);
      else n_pass++;
      cyc++;
      @(negedge clk);
    end
    instr = I_SW;
    exp_q.push_back(mk(3'd0, 1'b0, A_ADD, S_NONE));
    exp_q.push_back(mk(3'd1, 1'b1, A_ADD, S_NONE));
    exp_q.push_back(mk(3'd2, 1'b1, A_ADD, S_NONE));
    exp_q.push_back(mk(3'd3, 1'b1, A_ADD, S_MW));
    exp_q.push_back(mk(3'd4, 1'b1, A_ADD, S_LPC));
    exp_q.push_back(mk(3'd0, 1'b0, A_ADD, S_NONE));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); n_total++;
      if (obs[0] !== e) $display("FAIL b2b_sw_cyc%0d got=%h exp=%h", cyc, obs[0], e);
      else n_pass++;
      cyc++;
      if (exp_q.size() != 0) @(negedge clk);
    end
  endtask

`ifdef CTRL_INSTR_COUNT_EN
  task automatic test_retired();
    logic [31:0] rq [$];
    logic [31:0] r;
    do_reset();
    instr = I_ADD;
    rq.push_back(32'd3);
    repeat (15) @(negedge clk);
    r = rq.pop_front(); n_total++;
    if (g_dut[0].ret !== r) $display("FAIL retired_count got=%h exp=%h", g_dut[0].ret, r);
    else n_pass++;
    force g_dut[0].u_dut.retired_q = 32'hFFFFFFFE;
    #1 release g_dut[0].u_dut.retired_q;
    rq.push_back(32'd0);
    repeat (10) @(negedge clk);
    r = rq.pop_front(); n_total++;
    if (g_dut[0].ret !== r) $display("FAIL retired_wrap got=%h exp=%h", g_dut[0].ret, r);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_r_type();
    test_load();
    test_branch();
    test_shift_imm();
    test_alu_decode();
    test_unsupported();
    test_store_abort();
    test_back_to_back();
`ifdef CTRL_INSTR_COUNT_EN
    test_retired();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
